// File: rtl/addsub_result_accumulator.sv
// addsub_result_accumulator
// Collects NUM_SAMPLES results of the 4-bit adder-subtractor into a signed
// ACC_W-bit total and offers it on a valid/ready output. A flush closes a
// partial total early; a flush with nothing collected is ignored.
// Optional feature macro: ADDSUB_ACC_SAT_EN -- saturating accumulation with a
// sticky clamp flag on out_sat. Without it the total wraps and out_sat is 0.
module addsub_result_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_data,
  input  logic             in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam logic [7:0] NUM_W = 8'(NUM_SAMPLES);

  // Sums are unsigned (0..30), differences are 5-bit two's complement.
  function automatic logic [ACC_W-1:0] extend(input logic [4:0] d, input logic m);
    if (m) begin
      extend = {{(ACC_W-5){d[4]}}, d};
    end else begin
      extend = {{(ACC_W-5){1'b0}}, d};
    end
  endfunction

`ifdef ADDSUB_ACC_SAT_EN
  // Returns {clamped, result}; result is pinned to the signed range on overflow.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction
`endif

  state_t           state_r, next_state_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s, sum_s, ext_s;
  logic [7:0]       cnt_r, cnt_nxt_s, cnt_inc_s;
  logic             accept_s, close_s, clamp_s;
  logic             in_ready_r, out_valid_r;
  logic [ACC_W-1:0] out_data_r;
  logic [7:0]       out_count_r;
`ifdef ADDSUB_ACC_SAT_EN
  logic             sat_r, sat_nxt_s, out_sat_r;
`endif

  // Next-state decode plus the candidate accumulator/count values.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    close_s      = 1'b0;
    clamp_s      = 1'b0;
    ext_s        = extend(in_data, in_mode);
    cnt_inc_s    = cnt_r + 8'd1;
`ifdef ADDSUB_ACC_SAT_EN
    {clamp_s, sum_s} = sat_add(acc_r, ext_s);
`else
    sum_s = acc_r + ext_s;
`endif
    case (state_r)
      ST_ACCUM: begin
        accept_s = in_valid;
        close_s  = (accept_s && (cnt_inc_s == NUM_W)) ||
                   (flush && ((cnt_r != 8'd0) || accept_s));
        if (close_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          next_state_s = ST_ACCUM;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_ACCUM;
      end
    endcase
    // Sample data only matters on accept, so idle X on in_data never lands.
    if (accept_s) begin
      acc_nxt_s = sum_s;
      cnt_nxt_s = cnt_inc_s;
    end else begin
      acc_nxt_s = acc_r;
      cnt_nxt_s = cnt_r;
    end
`ifdef ADDSUB_ACC_SAT_EN
    sat_nxt_s = sat_r | (accept_s & clamp_s);
`endif
  end

  // State, running total and the held output record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACCUM;
      acc_r       <= '0;
      cnt_r       <= 8'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_count_r <= 8'd0;
`ifdef ADDSUB_ACC_SAT_EN
      sat_r       <= 1'b0;
      out_sat_r   <= 1'b0;
`endif
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == ST_ACCUM);
      out_valid_r <= (next_state_s == ST_DONE);
      case (state_r)
        ST_ACCUM: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_nxt_s;
`ifdef ADDSUB_ACC_SAT_EN
          sat_r <= sat_nxt_s;
`endif
          // Output record is captured only when a total closes.
          if (close_s) begin
            out_data_r  <= acc_nxt_s;
            out_count_r <= cnt_nxt_s;
`ifdef ADDSUB_ACC_SAT_EN
            out_sat_r   <= sat_nxt_s;
`endif
          end else begin
            out_data_r  <= out_data_r;
            out_count_r <= out_count_r;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc_r <= '0;
            cnt_r <= 8'd0;
`ifdef ADDSUB_ACC_SAT_EN
            sat_r <= 1'b0;
`endif
          end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
          end
        end
        default: begin
          acc_r <= '0;
          cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;
`ifdef ADDSUB_ACC_SAT_EN
  assign out_sat   = out_sat_r;
`else
  assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_result_accumulator.sv
// Directed bench for addsub_result_accumulator: a table of totals plus
// hand-written back-pressure, empty flush, reset and back-to-back sequences.
module tb_addsub_result_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_mode = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [4:0] in_data = 5'd0;
  logic       in_ready, out_valid, out_sat;
  logic [7:0] out_data, out_count;

  logic       w6_in_valid = 1'b0, w6_in_mode = 1'b0, w6_flush = 1'b0, w6_out_ready = 1'b0;
  logic [4:0] w6_in_data = 5'd0;
  logic       w6_in_ready, w6_out_valid, w6_out_sat;
  logic [5:0] w6_out_data;
  logic [7:0] w6_out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_result_accumulator #(.NUM_SAMPLES(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_sat(out_sat)
  );

  addsub_result_accumulator #(.NUM_SAMPLES(4), .ACC_W(6)) dut_w6 (
    .clk(clk), .rst_n(rst_n), .in_valid(w6_in_valid), .in_ready(w6_in_ready),
    .in_data(w6_in_data), .in_mode(w6_in_mode), .flush(w6_flush), .out_valid(w6_out_valid),
    .out_ready(w6_out_ready), .out_data(w6_out_data), .out_count(w6_out_count), .out_sat(w6_out_sat)
  );

  typedef struct packed {
    logic [3:0][4:0] d;
    logic [3:0]      m;
    logic [2:0]      n;
    logic [1:0]      fm;   // 0 none, 1 flush with last sample, 2 flush cycle after
    logic [7:0]      exp_data;
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input logic [4:0] d0, input logic [4:0] d1,
                              input logic [4:0] d2, input logic [4:0] d3,
                              input logic [3:0] m, input logic [2:0] n,
                              input logic [1:0] fm, input int ed, input int ec);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.m = m; v.n = n; v.fm = fm;
    v.exp_data = 8'(ed); v.exp_cnt = 8'(ec);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [4:0] d, input logic m, input logic f);
    in_valid = 1'b1; in_data = d; in_mode = m; flush = f;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; in_data = 5'bx; in_mode = 1'bx;
  endtask

  task automatic expect_total(input string name, input int ed, input int ec);
    chk({name, ".valid"}, int'(out_valid), 1);
    chk({name, ".in_ready"}, int'(in_ready), 0);
    chk({name, ".data"}, $signed(out_data), ed);
    chk({name, ".count"}, int'(out_count), ec);
    chk({name, ".sat"}, int'(out_sat), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".valid_clr"}, int'(out_valid), 0);
    chk({name, ".ready_back"}, int'(in_ready), 1);
    chk({name, ".data_held"}, $signed(out_data), ed);
  endtask

  int bb_idx, bb_first, bb_second, bb_vcycles;
  int bb_vals [2];
  logic bb_rdy;

  initial begin
    tbl[0] = mk(5'd12, 5'd30, 5'b11101, 5'd7, 4'b1100, 3'd4, 2'd0, 46, 4);
    tbl[1] = mk(5'd10, 5'd5, 5'd0, 5'd0, 4'b0000, 3'd2, 2'd2, 15, 2);
    tbl[2] = mk(5'd1, 5'd2, 5'b10001, 5'd0, 4'b0100, 3'd3, 2'd1, -12, 3);
    tbl[3] = mk(5'b10001, 5'b10001, 5'b10001, 5'b10001, 4'b1111, 3'd4, 2'd0, -60, 4);
    tbl[4] = mk(5'd30, 5'd30, 5'd30, 5'd30, 4'b0000, 3'd4, 2'd0, 120, 4);
    tbl[5] = mk(5'b01111, 5'd15, 5'b11111, 5'd0, 4'b0101, 3'd4, 2'd0, 29, 4);
    tbl[6] = mk(5'b10110, 5'd0, 5'd0, 5'd0, 4'b0001, 3'd1, 2'd1, -10, 1);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_data", int'(out_data), 0);
    chk("rst.out_count", int'(out_count), 0);
    chk("rst.out_sat", int'(out_sat), 0);
    chk("rst.w6_out_valid", int'(w6_out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of totals
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < int'(tbl[v].n); i++)
        send(tbl[v].d[i], tbl[v].m[i], (tbl[v].fm == 2'd1) && (i == int'(tbl[v].n) - 1));
      if (tbl[v].fm == 2'd2) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      expect_total($sformatf("vec%0d", v), $signed(tbl[v].exp_data), int'(tbl[v].exp_cnt));
    end

    // Back-pressure: DONE held for 5 cycles while samples are offered
    send(5'd1, 1'b0, 1'b0); send(5'd2, 1'b0, 1'b0);
    send(5'd3, 1'b0, 1'b0); send(5'd4, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 5'd9; in_mode = 1'b0;
      chk("bp.valid", int'(out_valid), 1);
      chk("bp.in_ready", int'(in_ready), 0);
      chk("bp.data", $signed(out_data), 10);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.ready_back", int'(in_ready), 1);
    chk("bp.valid_clr", int'(out_valid), 0);

    // Flush with nothing collected is ignored
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("flush0.no_out", int'(out_valid), 0);
      @(negedge clk);
    end
    send(5'd1, 1'b0, 1'b0); send(5'd1, 1'b0, 1'b0);
    send(5'd1, 1'b0, 1'b0); send(5'd1, 1'b0, 1'b0);
    expect_total("bp_after", 4, 4);

    // Reset mid-operation
    send(5'd20, 1'b0, 1'b0); send(5'd20, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.out_data", int'(out_data), 0);
    chk("mrst.out_count", int'(out_count), 0);
    chk("mrst.out_valid", int'(out_valid), 0);
    chk("mrst.in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst.no_emit", int'(out_valid), 0);
    send(5'd1, 1'b0, 1'b0); send(5'd1, 1'b0, 1'b0);
    send(5'd1, 1'b0, 1'b0);
    chk("mrst.no_early", int'(out_valid), 0);
    send(5'd1, 1'b0, 1'b0);
    expect_total("mrst_after", 4, 4);

    // Back-to-back totals with in_valid held high
    bb_idx = 0; bb_first = -1; bb_second = -1; bb_vcycles = 0;
    bb_vals[0] = 0; bb_vals[1] = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bb_idx < 8) begin
        in_valid = 1'b1; in_data = 5'(bb_idx + 1); in_mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      bb_rdy = in_ready;
      @(negedge clk);
      if (in_valid && bb_rdy) bb_idx++;
      if (out_valid) begin
        if (bb_vcycles < 2) bb_vals[bb_vcycles] = $signed(out_data);
        if (bb_vcycles == 0) bb_first = c;
        if (bb_vcycles == 1) bb_second = c;
        bb_vcycles++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b.consumed", bb_idx, 8);
    chk("b2b.totals", bb_vcycles, 2);
    chk("b2b.first", bb_vals[0], 10);
    chk("b2b.second", bb_vals[1], 26);
    chk("b2b.first_cycle", bb_first, 3);
    chk("b2b.period", bb_second - bb_first, 5);

    // ACC_W=6 overflow: four samples of 30
    for (int i = 0; i < 4; i++) begin
      w6_in_valid = 1'b1; w6_in_data = 5'd30; w6_in_mode = 1'b0;
      @(negedge clk);
    end
    w6_in_valid = 1'b0;
    chk("w6.valid", int'(w6_out_valid), 1);
    chk("w6.count", int'(w6_out_count), 4);
`ifdef ADDSUB_ACC_SAT_EN
    chk("w6.data", $signed(w6_out_data), 31);
    chk("w6.sat", int'(w6_out_sat), 1);
`else
    chk("w6.data", $signed(w6_out_data), -8);
    chk("w6.sat", int'(w6_out_sat), 0);
`endif
    w6_out_ready = 1'b1;
    @(negedge clk);
    w6_out_ready = 1'b0;
    chk("w6.valid_clr", int'(w6_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
